rsa_modexp_stream: RTL and testbench

- Parametrised bit-serial modular exponentiation engine: R = B^E mod N.
- Operands arrive as a 32-bit valid/ready word stream; the result leaves on a second 32-bit valid/ready stream.
- Sits between the RSA key buffer and the AES key path, and fills the ModExp step of the decryptor flow.
- Operand width is generic; one engine serves key sizes from 64 to 4096 bits.

---
 rtl/rsa_modexp_stream.sv | 190 +++++++++++++++++++
 tb/tb_rsa_modexp_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp_stream.sv
// Bit-serial modular exponentiation engine: R = B^E mod N.
// Operands N, E, B stream in as 32-bit words (LSW first); R streams out the same way.
// Optional build macro MODEXP_SKIP_LZ_EN: skip the leading zeros of E during CHECK.
module rsa_modexp_stream #(
    parameter int unsigned WIDTH = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic [31:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [31:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        err_o
);
    localparam int unsigned NW = WIDTH / 32;
    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(3 * NW);
    localparam int unsigned PW = WIDTH + 2;

    typedef enum logic [2:0] {StLoad, StCheck, StErr, StSqr, StMul, StOut} state_e;

    state_e              state_q, state_d;
    logic [3*WIDTH-1:0]  opnd_q, opnd_d;     // {B, E, N}, filled by right shift
    logic [WIDTH-1:0]    r_q, r_d;
    logic [PW-1:0]       p_q, p_d;
    logic [IW-1:0]       i_q, i_d, j_q, j_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mm_run_q, mm_run_d; // 0: next MM cycle is the setup cycle
    logic                err_q, err_d;

    logic [WIDTH-1:0]    n_w, e_w, b_w, y_w, one_mod_n;
    logic [PW-1:0]       n_ext, p_dbl, p_s1, p_s2;
    logic                chk_fail;

    assign n_w       = opnd_q[WIDTH-1:0];
    assign e_w       = opnd_q[2*WIDTH-1:WIDTH];
    assign b_w       = opnd_q[3*WIDTH-1:2*WIDTH];
    assign n_ext     = {2'b00, n_w};
    assign y_w       = (state_q == StSqr) ? r_q : b_w;
    assign one_mod_n = (n_w == WIDTH'(1)) ? '0 : WIDTH'(1);
    assign chk_fail  = (n_w == '0) || (b_w >= n_w);

    // One shift-add step of the MM: P stays below 3N, so two conditional subtracts reduce it.
    assign p_dbl = (p_q << 1) + (r_q[j_q] ? {2'b00, y_w} : '0);
    assign p_s1  = (p_dbl >= n_ext) ? p_dbl - n_ext : p_dbl;
    assign p_s2  = (p_s1 >= n_ext) ? p_s1 - n_ext : p_s1;

`ifdef MODEXP_SKIP_LZ_EN
    logic [IW-1:0] msb_idx;

    // Priority encode the highest set bit of E; only used when E is nonzero.
    always_comb begin
        msb_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (e_w[k]) msb_idx = IW'(k);
        end
    end
`endif

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StLoad;
            opnd_q   <= '0;
            r_q      <= '0;
            p_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            cnt_q    <= '0;
            mm_run_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opnd_q   <= opnd_d;
            r_q      <= r_d;
            p_q      <= p_d;
            i_q      <= i_d;
            j_q      <= j_d;
            cnt_q    <= cnt_d;
            mm_run_q <= mm_run_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic and outputs.
    always_comb begin
        state_d     = state_q;
        opnd_d      = opnd_q;
        r_d         = r_q;
        p_d         = p_q;
        i_d         = i_q;
        j_d         = j_q;
        cnt_d       = cnt_q;
        mm_run_d    = mm_run_q;
        err_d       = err_q;
        in_ready_o  = (state_q == StLoad);
        out_valid_o = (state_q == StOut);
        out_data_o  = (state_q == StOut) ? r_q[31:0] : '0;
        busy_o      = (state_q == StCheck) || (state_q == StSqr) || (state_q == StMul);
        err_o       = err_q;

        unique case (state_q)
            StLoad: begin
                if (in_valid_i) begin
                    opnd_d = {in_data_i, opnd_q[3*WIDTH-1:32]};
                    if (cnt_q == '0) err_d = 1'b0;
                    if (cnt_q == CW'(3 * NW - 1)) begin
                        cnt_d   = '0;
                        state_d = StCheck;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StCheck: begin
                if (!stall_i) begin
                    mm_run_d = 1'b0;
                    if (chk_fail) begin
                        state_d = StErr;
                    end else begin
`ifdef MODEXP_SKIP_LZ_EN
                        if (e_w == '0) begin
                            r_d     = one_mod_n;
                            state_d = StOut;
                        end else begin
                            // B < N here, so R = B equals the result after the bit-h MUL.
                            r_d = b_w;
                            if (msb_idx == '0) begin
                                state_d = StOut;
                            end else begin
                                i_d     = msb_idx - IW'(1);
                                state_d = StSqr;
                            end
                        end
`else
                        r_d     = one_mod_n;
                        i_d     = IW'(WIDTH - 1);
                        state_d = StSqr;
`endif
                    end
                end
            end
            StErr: begin
                err_d   = 1'b1;
                state_d = StLoad;
            end
            StSqr, StMul: begin
                if (!stall_i) begin
                    if (!mm_run_q) begin
                        p_d      = '0;
                        j_d      = IW'(WIDTH - 1);
                        mm_run_d = 1'b1;
                    end else begin
                        p_d = p_s2;
                        j_d = j_q - IW'(1);
                        if (j_q == '0) begin
                            r_d      = p_s2[WIDTH-1:0];
                            mm_run_d = 1'b0;
                            if (state_q == StSqr && e_w[i_q]) begin
                                state_d = StMul;
                            end else if (i_q == '0) begin
                                state_d = StOut;
                            end else begin
                                i_d     = i_q - IW'(1);
                                state_d = StSqr;
                            end
                        end
                    end
                end
            end
            StOut: begin
                if (out_ready_i) begin
                    r_d = r_q >> 32;
                    if (cnt_q == CW'(NW - 1)) begin
                        cnt_d   = '0;
                        state_d = StLoad;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

endmodule

// File: tb/tb_rsa_modexp_stream.sv
// Self-checking bench for rsa_modexp_stream at WIDTH=64 (two words per operand).
// Expected results come from a right-to-left square-and-multiply model; latencies from E's bits.
module tb_rsa_modexp_stream;
    localparam int unsigned WIDTH = 64;
    localparam int NW = 2;

    logic        clk = 1'b0;
    logic        rst, stall_i, in_valid_i, out_ready_i;
    logic [31:0] in_data_i, out_data_o;
    logic        in_ready_o, out_valid_o, busy_o, err_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [63:0] n, e, b, exp;
        bit          is_err;
        int          rmode;
        int          smode;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rsa_modexp_stream #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .out_data_o (out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    function automatic vec_t mk(input logic [63:0] n, e, b, input bit is_err,
                                input logic [63:0] exp, input int rmode, input int smode);
        vec_t v;
        v.n = n; v.e = e; v.b = b; v.is_err = is_err; v.exp = exp;
        v.rmode = rmode; v.smode = smode;
        return v;
    endfunction

    function automatic logic [63:0] ref_modexp(input logic [63:0] n, e, b);
        logic [127:0] acc, base, nn;
        nn   = {64'd0, n};
        acc  = 128'd1 % nn;
        base = {64'd0, b} % nn;
        for (int k = 0; k < 64; k++) begin
            if (e[k]) acc = (acc * base) % nn;
            base = (base * base) % nn;
        end
        return 64'(acc);
    endfunction

    function automatic int exp_lat(input logic [63:0] e);
        int pop;
        pop = 0;
        for (int k = 0; k < 64; k++) if (e[k]) pop++;
`ifdef MODEXP_SKIP_LZ_EN
        begin
            int h;
            h = 0;
            for (int k = 0; k < 64; k++) if (e[k]) h = k;
            if (e == 64'd0) return 1;
            return 1 + 65 * (h + pop - 1);
        end
`else
        return 1 + 65 * (64 + pop);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready_o}, 64'd1);
        chk({tag, "_out_valid"}, {63'd0, out_valid_o}, 64'd0);
        chk({tag, "_out_data"}, {32'd0, out_data_o}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
        chk({tag, "_err"}, {63'd0, err_o}, 64'd0);
    endtask

    task automatic send_word(input logic [31:0] w);
        int t;
        t = 0;
        @(negedge clk);
        in_valid_i = 1'b1;
        in_data_i  = w;
        while (!in_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_o) chk("in_ready_timeout", {63'd0, in_ready_o}, 64'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    // Sends the first 'count' words of N, E, B (LSW first).
    task automatic send_job(input logic [63:0] n, e, b, input int count);
        logic [191:0] pk;
        pk = {b, e, n};
        for (int k = 0; k < count; k++) begin
            send_word(pk[k*32 +: 32]);
            if (k == 0) chk("err_clear_first_word", {63'd0, err_o}, 64'd0);
        end
    endtask

    task automatic collect(input int rmode, output logic [63:0] res);
        int          got, c;
        bit          pend;
        logic [31:0] prev;
        got = 0; c = 0; pend = 1'b0; prev = '0; res = '0;
        while (got < NW && c < 300) begin
            @(negedge clk);
            c++;
            out_ready_i = (rmode == 0) ? 1'b1 : ((c > 10) && (c % 2 == 0));
            if (pend && out_valid_o) chk("out_data_stable", {32'd0, out_data_o}, {32'd0, prev});
            if (out_valid_o && out_ready_i) begin
                res[got*32 +: 32] = out_data_o;
                got++;
                pend = 1'b0;
            end else if (out_valid_o) begin
                pend = 1'b1;
                prev = out_data_o;
            end
        end
        chk("out_word_count", 64'(got), 64'(NW));
        @(negedge clk);
        out_ready_i = 1'b0;
        chk("out_valid_drop", {63'd0, out_valid_o}, 64'd0);
        begin
            bit extra;
            extra = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (out_valid_o) extra = 1'b1;
            end
            chk("no_extra_words", {63'd0, extra}, 64'd0);
        end
    endtask

    task automatic do_job(input vec_t v);
        int          lat, want;
        logic [63:0] res;
        send_job(v.n, v.e, v.b, 3 * NW);
        chk("busy_in_check", {63'd0, busy_o}, {63'd0, !v.is_err || 1'b1});
        chk("in_ready_low", {63'd0, in_ready_o}, 64'd0);
        lat = 0;
        while (!(out_valid_o || err_o) && lat < 20000) begin
            stall_i = (v.smode != 0) && lat >= 100 && lat < 105;
            @(posedge clk);
            #1;
            lat++;
        end
        stall_i = 1'b0;
        if (v.is_err) begin
            bit seen;
            chk("err_flag", {63'd0, err_o}, 64'd1);
            chk("err_latency", 64'(lat), 64'd2);
            seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (out_valid_o) seen = 1'b1;
            end
            chk("err_no_output", {63'd0, seen}, 64'd0);
            chk("err_sticky", {63'd0, err_o}, 64'd1);
        end else begin
            want = exp_lat(v.e) + ((v.smode != 0) ? 5 : 0);
            chk("out_valid_seen", {63'd0, out_valid_o}, 64'd1);
            chk("latency", 64'(lat), 64'(want));
            collect(v.rmode, res);
            chk("result", res, v.exp);
        end
    endtask

    initial begin
        logic [63:0] rn, re, rb;
        rst = 1'b1; stall_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;

        vecs.push_back(mk(64'd497, 64'd13, 64'd4, 1'b0, 64'd445, 0, 0));
        vecs.push_back(mk(64'd497, 64'd0, 64'd4, 1'b0, 64'd1, 0, 0));
        vecs.push_back(mk(64'd497, 64'd13, 64'd500, 1'b1, 64'd0, 0, 0));
        vecs.push_back(mk(64'd497, 64'd13, 64'd4, 1'b0, 64'd445, 1, 1));
        vecs.push_back(mk(64'd1, 64'd5, 64'd0, 1'b0, 64'd0, 0, 0));
        vecs.push_back(mk(64'd0, 64'd5, 64'd3, 1'b1, 64'd0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            rn = {$urandom, $urandom} | 64'd2;
            re = {$urandom, $urandom};
            rb = {$urandom, $urandom} % rn;
            vecs.push_back(mk(rn, re, rb, 1'b0, ref_modexp(rn, re, rb), k % 2, 0));
        end

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) do_job(vecs[k]);

        // Reset in the middle of the SQR loop.
        send_job(64'd497, 64'd13, 64'd4, 3 * NW);
        repeat (200) @(posedge clk);
        #1;
        chk("busy_mid_sqr", {63'd0, busy_o}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("rst_mid_sqr");
        @(negedge clk);
        rst = 1'b0;

        // Reset part-way through a load, then a fresh full job.
        send_job(64'd12345, 64'd77, 64'd999, 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("rst_mid_load");
        @(negedge clk);
        rst = 1'b0;
        do_job(mk(64'd497, 64'd13, 64'd4, 1'b0, 64'd445, 0, 0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
